ldpc_iter_ctrl: RTL and testbench

LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

---
 rtl/ldpc_iter_ctrl.sv | 132 +++++++++++++
 tb/tb_ldpc_iter_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ldpc_iter_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : ldpc_iter_ctrl
// Purpose  : LOAD / CNU / VNU / CHECK sequencer for an iterative LDPC decoder.
//            Define LDPC_EARLY_TERM_EN to stop as soon as the syndrome is clean.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ldpc_iter_ctrl #(
  parameter int MAX_ITER   = 10,
  parameter int CNU_CYCLES = 1,
  parameter int VNU_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       syndrome_ok,
  output logic       ld_en,
  output logic       cnu_en,
  output logic       vnu_en,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic [7:0] iter_count
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_cnu   = 3'd2;
  localparam logic [2:0] c_st_vnu   = 3'd3;
  localparam logic [2:0] c_st_check = 3'd4;
  localparam logic [2:0] c_st_done  = 3'd5;

  localparam logic [3:0] c_cnu_last = 4'(CNU_CYCLES - 1);
  localparam logic [3:0] c_vnu_last = 4'(VNU_CYCLES - 1);
  localparam logic [7:0] c_max_iter = 8'(MAX_ITER);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [3:0] r_phase;
  logic [7:0] r_iter;
  logic       r_converged;
  logic [7:0] w_iter_inc;
  logic       w_ld_nxt, w_cnu_nxt, w_vnu_nxt, w_busy_nxt, w_done_nxt;
  logic       r_ld, r_cnu, r_vnu, r_busy, r_done;

  assign w_iter_inc = r_iter + 8'd1;

  // State register, phase/iteration counters and output flops.
  // Outputs are registered from the next state so they change only on clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_phase     <= 4'd0;
      r_iter      <= 8'd0;
      r_converged <= 1'b0;
      r_ld        <= 1'b0;
      r_cnu       <= 1'b0;
      r_vnu       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ld    <= w_ld_nxt;
      r_cnu   <= w_cnu_nxt;
      r_vnu   <= w_vnu_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;

      if (w_state_nxt != r_state)
        r_phase <= 4'd0;
      else if (r_state == c_st_cnu || r_state == c_st_vnu)
        r_phase <= r_phase + 4'd1;

      if (r_state == c_st_idle && start) begin
        r_iter      <= 8'd0;
        r_converged <= 1'b0;
      end else if (r_state == c_st_check && !abort) begin
        r_iter <= w_iter_inc;
        if (w_state_nxt == c_st_done)
          r_converged <= syndrome_ok;
      end
    end
  end

  // Next-state logic; abort outranks every other exit from a busy state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_load;
      c_st_load:  w_state_nxt = abort ? c_st_idle : c_st_cnu;
      c_st_cnu: begin
        if (abort)                     w_state_nxt = c_st_idle;
        else if (r_phase == c_cnu_last) w_state_nxt = c_st_vnu;
      end
      c_st_vnu: begin
        if (abort)                     w_state_nxt = c_st_idle;
        else if (r_phase == c_vnu_last) w_state_nxt = c_st_check;
      end
      c_st_check: begin
        if (abort)                          w_state_nxt = c_st_idle;
        else if (w_iter_inc == c_max_iter)  w_state_nxt = c_st_done;
`ifdef LDPC_EARLY_TERM_EN
        else if (syndrome_ok)               w_state_nxt = c_st_done;
`endif
        else                                w_state_nxt = c_st_cnu;
      end
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_ld_nxt   = (w_state_nxt == c_st_load);
    w_cnu_nxt  = (w_state_nxt == c_st_cnu);
    w_vnu_nxt  = (w_state_nxt == c_st_vnu);
    w_busy_nxt = (w_state_nxt != c_st_idle);
    w_done_nxt = (w_state_nxt == c_st_done);
  end

  assign ld_en      = r_ld;
  assign cnu_en     = r_cnu;
  assign vnu_en     = r_vnu;
  assign busy       = r_busy;
  assign done       = r_done;
  assign converged  = r_converged;
  assign iter_count = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_ldpc_iter_ctrl.sv
// Scoreboard bench for ldpc_iter_ctrl (MAX_ITER=4, CNU_CYCLES=2, VNU_CYCLES=1).
`default_nettype none

module tb_ldpc_iter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       syndrome_ok = 1'b0;
  logic       ld_en, cnu_en, vnu_en, busy, done, converged;
  logic [7:0] iter_count;

  ldpc_iter_ctrl #(.MAX_ITER(4), .CNU_CYCLES(2), .VNU_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .syndrome_ok(syndrome_ok), .ld_en(ld_en), .cnu_en(cnu_en),
    .vnu_en(vnu_en), .busy(busy), .done(done), .converged(converged),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] iter;
    logic       conv;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   excl_viol = 0;
  int   c0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Monitor: pops one expected frame result per done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (int'(ld_en) + int'(cnu_en) + int'(vnu_en) > 1) excl_viol++;
      if (done) begin
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("iter_count", int'(iter_count), int'(e.iter));
          chk("converged", int'(converged), int'(e.conv));
        end
      end
    end
  end

  // Raise start at a negedge; c0 marks cycle 0, the edge that samples it.
  task automatic pulse_start(input int done_rel, input int it, input int cv,
                             input bit expect_done);
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    start = 1'b1;
    if (expect_done) begin
      e.cyc = c0 + done_rel; e.iter = 8'(it); e.conv = cv[0];
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
    repeat (3) @(negedge clk);
    syndrome_ok = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_outputs", int'({ld_en, cnu_en, vnu_en, busy, done, converged, iter_count}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_done_after_reset", int'(done), 0);

    // Full frame, syndrome never clean
    pulse_start(18, 4, 0, 1'b1);
    chk("ld_en_cycle1", int'({ld_en, cnu_en, vnu_en}), 3'b100);
    @(negedge clk);
    chk("cnu_en_cycle2", int'({ld_en, cnu_en, vnu_en}), 3'b010);
    repeat (2) @(negedge clk);
    chk("vnu_en_cycle4", int'({ld_en, cnu_en, vnu_en}), 3'b001);
    wait_idle();

    // Syndrome clean from the 2nd CHECK onward
`ifdef LDPC_EARLY_TERM_EN
    pulse_start(10, 2, 1, 1'b1);
`else
    pulse_start(18, 4, 1, 1'b1);
`endif
    repeat (5) @(negedge clk);
    syndrome_ok = 1'b1;
    wait_idle();

    // Syndrome clean throughout
    syndrome_ok = 1'b1;
`ifdef LDPC_EARLY_TERM_EN
    pulse_start(6, 1, 1, 1'b1);
`else
    pulse_start(18, 4, 1, 1'b1);
`endif
    wait_idle();

    // start re-pulsed while busy must be ignored
    pulse_start(18, 4, 0, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Abort in the 3rd VNU phase (cycle 12)
    pulse_start(0, 0, 0, 1'b0);
    repeat (11) @(negedge clk);
    chk("vnu3_active", int'(vnu_en), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", int'(busy), 0);
    chk("abort_iter", int'(iter_count), 2);
    repeat (5) @(negedge clk);
    pulse_start(18, 4, 0, 1'b1);
    wait_idle();

    // Reset in the 2nd CNU phase (cycle 6)
    pulse_start(0, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("cnu_active", int'(cnu_en), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'({ld_en, cnu_en, vnu_en, busy, done, converged, iter_count}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_start(18, 4, 0, 1'b1);
    wait_idle();

    chk("exclusive_enables", excl_viol, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
